// File: rtl/fp_add_pipe.sv
// Three-stage pipelined binary32 adder (align / add / normalize-round) with
// special-result passthrough and a single global stall driven by the output handshake.
module fp_add_pipe #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW+MW:0] NA,
    input  logic [EW+MW:0] NB,
    input  logic          EN,
    input  logic [EW+MW:0] S,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW+MW:0] SUM,
    output logic          OVF
);
    localparam int W  = 1 + EW + MW;
    localparam int SW = MW + 1;   // significand incl. hidden bit
    localparam int XW = SW + 3;   // plus guard, round, sticky
    localparam int AW = XW + 1;   // plus carry
    localparam int XE = EW + 2;   // headroom for carry and rounding increments

    function automatic logic [XW-1:0] align_small(input logic [SW-1:0] sig, input logic [EW-1:0] d);
        logic [XW-1:0] ext;
        logic [XW-1:0] shifted;
        logic [XW-1:0] lost_mask;
        logic          sticky;
        ext       = {sig, 3'b000};
        lost_mask = '0;
        if (d >= EW'(XW)) begin
            shifted = '0;
            sticky  = |sig;
        end else begin
            shifted   = ext >> d;
            lost_mask = (XW'(1) << d) - XW'(1);
            sticky    = |(ext & lost_mask);
        end
        return {shifted[XW-1:1], shifted[0] | sticky};
    endfunction

    // Returns {overflow, packed result}.
    function automatic logic [W:0] norm_round(input logic [AW-1:0] sum, input logic [EW-1:0] e,
                                              input logic sign, input logic sub);
        logic [XW-1:0] m;
        logic [XE-1:0] ex;
        logic [XE-1:0] lz;
        logic [XE-1:0] sh;
        logic [SW:0]   rnd;
        logic          up;
        logic          rs;
        lz = XE'(XW);
        for (int i = 0; i < XW; i++)
            if (sum[i]) lz = XE'(XW - 1 - i);
        sh = '0;
        if (sum[AW-1]) begin
            m  = {sum[AW-1:2], sum[1] | sum[0]};
            ex = XE'(e) + XE'(1);
        end else begin
            // Never normalize below the minimum exponent; what remains is subnormal.
            sh = (lz < XE'(e) - XE'(1)) ? lz : XE'(e) - XE'(1);
            m  = sum[XW-1:0] << sh;
            ex = XE'(e) - sh;
        end
        if (!m[XW-1]) ex = '0;
        up  = m[2] & (m[1] | m[0] | m[3]);
        rnd = {1'b0, m[XW-1:3]} + (SW+1)'(up);
        if (rnd[SW])
            ex = ex + XE'(1);
        else if (ex == '0 && rnd[SW-1])
            ex = XE'(1);
        rs = (sub && sum == '0) ? 1'b0 : sign;
        if (ex >= XE'((1 << EW) - 1))
            return {1'b1, rs, {EW{1'b1}}, {MW{1'b0}}};
        return {1'b0, rs, ex[EW-1:0], rnd[MW-1:0]};
    endfunction

    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    logic                a_big;
    logic [EW+MW-1:0]    mag_big, mag_small;
    logic [EW-1:0]       e_big, e_small, d;
    logic [SW-1:0]       sig_big, sig_small;

    always_comb begin
        a_big     = NA[EW+MW-1:0] >= NB[EW+MW-1:0];
        mag_big   = a_big ? NA[EW+MW-1:0] : NB[EW+MW-1:0];
        mag_small = a_big ? NB[EW+MW-1:0] : NA[EW+MW-1:0];
        e_big     = (mag_big[EW+MW-1:MW] == '0) ? EW'(1) : mag_big[EW+MW-1:MW];
        e_small   = (mag_small[EW+MW-1:MW] == '0) ? EW'(1) : mag_small[EW+MW-1:MW];
        sig_big   = {mag_big[EW+MW-1:MW] != '0, mag_big[MW-1:0]};
        sig_small = {mag_small[EW+MW-1:MW] != '0, mag_small[MW-1:0]};
        d         = e_big - e_small;
    end

    logic [XW-1:0] big_p1, small_p1;
    logic [EW-1:0] exp_p1, exp_p2;
    logic          sign_p1, sub_p1, en_p1, sign_p2, sub_p2, en_p2;
    logic [W-1:0]  s_p1, s_p2;
    logic [AW-1:0] sum_p2;
    logic          vld_p1, vld_p2;
    logic [W:0]    res;

    // Stage 1: align the smaller operand
    always_ff @(posedge clk) begin
        if (adv) begin
            big_p1   <= {sig_big, 3'b000};
            small_p1 <= align_small(sig_small, d);
            exp_p1   <= e_big;
            sign_p1  <= a_big ? NA[W-1] : NB[W-1];
            sub_p1   <= NA[W-1] ^ NB[W-1];
            en_p1    <= EN;
            s_p1     <= S;
        end
    end

    // Stage 2: magnitude add or subtract
    always_ff @(posedge clk) begin
        if (adv) begin
            sum_p2  <= sub_p1 ? ({1'b0, big_p1} - {1'b0, small_p1})
                              : ({1'b0, big_p1} + {1'b0, small_p1});
            exp_p2  <= exp_p1;
            sign_p2 <= sign_p1;
            sub_p2  <= sub_p1;
            en_p2   <= en_p1;
            s_p2    <= s_p1;
        end
    end

    // Stage 3: normalize, round, pack
    assign res = norm_round(sum_p2, exp_p2, sign_p2, sub_p2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            SUM       <= '0;
            OVF       <= 1'b0;
        end else if (adv) begin
            vld_p1    <= in_valid;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            SUM       <= en_p2 ? res[W-1:0] : s_p2;
            OVF       <= en_p2 & res[W];
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: directed vector table, latency/stall/reset sequences, and random
// operands scored against an exact-integer rounding model.
module tb_fp_add_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] NA = '0, NB = '0, S = '0;
    logic        EN = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] SUM;
    logic        OVF;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    typedef struct packed {logic [31:0] sum; logic ovf;} exp_t;
    typedef struct {
        logic [31:0] a, b, s;
        logic        en;
        logic [31:0] sum;
        logic        ovf;
    } vec_t;

    exp_t exp_q[$];
    vec_t tab[16];

    fp_add_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .NA(NA), .NB(NB), .EN(EN), .S(S),
        .out_valid(out_valid), .out_ready(out_ready), .SUM(SUM), .OVF(OVF)
    );

    always #5 clk = ~clk;

    // Exact sum in units of 2^-149, then round-to-nearest-even into binary32.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] one, va, vb, mag, rem, half;
        logic         sgn;
        logic [24:0]  q;
        int           ea, eb, p, k, eb_out;
        one = 300'd1;
        ea  = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        eb  = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        va  = 300'({a[30:23] != 8'd0, a[22:0]}) << (ea - 1);
        vb  = 300'({b[30:23] != 8'd0, b[22:0]}) << (eb - 1);
        if (a[31] == b[31]) begin
            mag = va + vb; sgn = a[31];
        end else if (va >= vb) begin
            mag = va - vb; sgn = (va == vb) ? 1'b0 : a[31];
        end else begin
            mag = vb - va; sgn = b[31];
        end
        if (mag < (one << 24)) return {1'b0, sgn, mag[30:0]};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        k    = p - 23;
        q    = 25'(mag >> k);
        rem  = mag & ((one << k) - one);
        half = one << (k - 1);
        if (rem > half || (rem == half && q[0])) q = q + 25'd1;
        if (q[24]) begin q = q >> 1; k = k + 1; end
        eb_out = k + 1;
        if (eb_out >= 255) return {1'b1, sgn, 8'hFF, 23'd0};
        return {1'b0, sgn, 8'(eb_out), q[22:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase after acceptance.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                        input logic en, input logic [31:0] esum, input logic eovf);
        logic acc;
        int   c;
        exp_q.push_back('{esum, eovf});
        in_valid = 1'b1; NA = a; NB = b; S = s; EN = en;
        c = 0;
        forever begin
            #7; acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
            c++;
            if (c >= 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout in_ready stuck low for %0d cycles", c);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = ref_add(a, b);
        send(a, b, 32'h0, 1'b1, r[31:0], r[32]);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin sync(); c++; end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic lat_check(input logic [31:0] a, input logic [31:0] b, input logic [31:0] esum,
                             input logic eovf, input string tag);
        exp_q.push_back('{esum, eovf});
        in_valid = 1'b1; NA = a; NB = b; EN = 1'b1; S = '0;
        #7; chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        sync(); chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
        sync(); chk({tag, "_lat3"}, 32'(out_valid), 32'd1);
    endtask

    function automatic logic [31:0] rand_fin(input int e);
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_output SUM=%h OVF=%b required none", SUM, OVF);
            end else begin
                e = exp_q.pop_front();
                if (SUM !== e.sum || OVF !== e.ovf) begin
                    errors++;
                    $display("FAIL result SUM=%h OVF=%b required SUM=%h OVF=%b", SUM, OVF, e.sum, e.ovf);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic  done;
        int    ea, eb, p0;
        logic [31:0] a, b, s;
        logic  en;
        logic [32:0] r;

        tab[0]  = '{32'h3F800000, 32'h3F800000, 32'h0, 1'b1, 32'h40000000, 1'b0};
        tab[1]  = '{32'h3F800000, 32'hBF800000, 32'h0, 1'b1, 32'h00000000, 1'b0};
        tab[2]  = '{32'h00000001, 32'h00000001, 32'h0, 1'b1, 32'h00000002, 1'b0};
        tab[3]  = '{32'h3F800000, 32'h33800000, 32'h0, 1'b1, 32'h3F800000, 1'b0};
        tab[4]  = '{32'h3F800001, 32'h33800000, 32'h0, 1'b1, 32'h3F800002, 1'b0};
        tab[5]  = '{32'h3F800000, 32'h33800001, 32'h0, 1'b1, 32'h3F800001, 1'b0};
        tab[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 1'b1, 32'h7F800000, 1'b1};
        tab[7]  = '{32'h3F800000, 32'h3F800000, 32'hFF800001, 1'b0, 32'hFF800001, 1'b0};
        tab[8]  = '{32'h40400000, 32'h3F800000, 32'h0, 1'b1, 32'h40800000, 1'b0};
        tab[9]  = '{32'hBF800000, 32'hBF800000, 32'h0, 1'b1, 32'hC0000000, 1'b0};
        tab[10] = '{32'h80000000, 32'h80000000, 32'h0, 1'b1, 32'h80000000, 1'b0};
        tab[11] = '{32'h80000000, 32'h00000000, 32'h0, 1'b1, 32'h00000000, 1'b0};
        tab[12] = '{32'h00800000, 32'h80000001, 32'h0, 1'b1, 32'h007FFFFF, 1'b0};
        tab[13] = '{32'h007FFFFF, 32'h00000001, 32'h0, 1'b1, 32'h00800000, 1'b0};
        tab[14] = '{32'h3F800000, 32'hBF7FFFFF, 32'h0, 1'b1, 32'h33800000, 1'b0};
        tab[15] = '{32'h7F7FFFFF, 32'h73000000, 32'h0, 1'b1, 32'h7F800000, 1'b1};

        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", SUM, 32'd0);
        chk("reset_ovf", 32'(OVF), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        lat_check(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, "one_plus_one");
        sync();

        for (int i = 0; i < 16; i++)
            send(tab[i].a, tab[i].b, tab[i].s, tab[i].en, tab[i].sum, tab[i].ovf);
        drain("table_drain");

        // Six back-to-back sums with a four-cycle output stall in the middle.
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ea = $urandom_range(1, 200);
                    send_model(rand_fin(ea), rand_fin(ea + $urandom_range(0, 3)));
                end
            end
            begin
                int c;
                c = 0;
                do begin @(posedge clk); #2; c++; end while (!out_valid && c < 50);
                out_ready = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    #1;
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    @(posedge clk); #2;
                end
                out_ready = 1'b1;
            end
        join
        sync();
        drain("bp_drain");
        chk("bp_count", 32'(pops - p0), 32'd6);

        // Reset with three entries in flight.
        send(32'h40400000, 32'h3F800000, 32'h0, 1'b1, 32'h40800000, 1'b0);
        send(32'h3F800000, 32'hBF800000, 32'h0, 1'b1, 32'h00000000, 1'b0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 1'b1, 32'h7F800000, 1'b1);
        chk("rst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_sum", SUM, 32'd0);
        chk("rst_mid_ovf", 32'(OVF), 32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        lat_check(32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, "post_reset");
        for (int i = 0; i < 6; i++) sync();
        drain("post_reset_drain");

        // Random operands with random output back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ea = $urandom_range(0, 254);
                    case ($urandom_range(0, 5))
                        0: eb = $urandom_range(0, 254);
                        1: eb = ea;
                        2: eb = ea + $urandom_range(0, 30) - 15;
                        3: begin ea = $urandom_range(0, 3); eb = 0; end
                        default: eb = ea + $urandom_range(0, 2) - 1;
                    endcase
                    if (eb < 0) eb = 0;
                    if (eb > 254) eb = 254;
                    a = rand_fin(ea);
                    b = rand_fin(eb);
                    if ($urandom_range(0, 9) == 0) b = a ^ 32'h80000000;
                    en = ($urandom_range(0, 7) != 0);
                    s  = $urandom;
                    r  = en ? ref_add(a, b) : {1'b0, s};
                    send(a, b, s, en, r[31:0], r[32]);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        sync();
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
